pifo_dequeue_ctrl: RTL and testbench

PIFO_DEQUEUE_CTRL -- requirements
Module: pifo_dequeue_ctrl

---
 rtl/pifo_dequeue_ctrl.sv | 157 +++++++++++++++
 tb/tb_pifo_dequeue_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_dequeue_ctrl.sv
// rtl/pifo_dequeue_ctrl.sv - PIFO dequeue controller with quantum reinsert, pop spacing and 2-entry output buffer
module pifo_dequeue_ctrl #(
  parameter int PRIO_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int QUANTUM    = 16,
  parameter int GAP        = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__enable,
  input  logic                  i__drain,
  input  logic                  i__pifo_pop_valid,
  input  logic [PRIO_WIDTH-1:0] i__pifo_pop_priority,
  input  logic [DATA_WIDTH-1:0] i__pifo_pop_data,
  output logic                  o__pifo_pop,
  output logic [PRIO_WIDTH-1:0] o__pifo_reinsert_priority,
  output logic                  o__deq_valid,
  output logic [DATA_WIDTH-1:0] o__deq_data,
  output logic [PRIO_WIDTH-1:0] o__deq_priority,
  input  logic                  i__deq_ready,
  output logic [CNT_WIDTH-1:0]  o__pop_count,
  output logic                  o__drain_done
);

  // Gap counter needs to hold GAP; keep at least one bit when GAP is 0.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0]         GAP_LOAD = GW'(GAP);
  localparam logic [PRIO_WIDTH-1:0] QUANT    = PRIO_WIDTH'(QUANTUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [GW-1:0]         gap_cnt;
  logic                  sec_valid;
  logic [DATA_WIDTH-1:0] sec_data;
  logic [PRIO_WIDTH-1:0] sec_prio;
  logic [1:0]            occupancy;
  logic                  accept;
  logic                  popping_state;

  // The head of the output buffer lives directly in the o__deq_* registers;
  // the second slot holds the entry queued behind it.
  assign occupancy     = {1'b0, o__deq_valid} + {1'b0, sec_valid};
  assign accept        = o__deq_valid & i__deq_ready;
  assign popping_state = (state == RUN) || (state == DRAIN);

  // Pop decision is combinational and gated by reset so nothing leaks out while held in reset.
  always_comb begin
    o__pifo_pop               = 1'b0;
    o__pifo_reinsert_priority = '0;
    if (reset && popping_state && i__pifo_pop_valid && (gap_cnt == '0) && (occupancy < 2'd2)) begin
      o__pifo_pop = 1'b1;
      if ((state == RUN) && (i__pifo_pop_priority > QUANT)) begin
        o__pifo_reinsert_priority = i__pifo_pop_priority - QUANT;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a drain request out of RUN wins over enable dropping.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i__enable) state_next = RUN;
      end
      RUN: begin
        if (i__drain)       state_next = DRAIN;
        else if (!i__enable) state_next = IDLE;
      end
      DRAIN: begin
        if (!i__pifo_pop_valid && !o__pifo_pop && (occupancy == 2'd0)) state_next = DONE;
      end
      DONE: begin
        if (!i__enable && !i__drain) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o__drain_done = (state == DONE);

  // Gap counter: reload on every pop, count down to zero and stay there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (o__pifo_pop) begin
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // Pop counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o__pop_count <= '0;
    end else if (o__pifo_pop) begin
      o__pop_count <= o__pop_count + CNT_WIDTH'(1);
    end
  end

  // Two-entry output FIFO: shift on downstream accept, append popped entry behind whatever remains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o__deq_valid    <= 1'b0;
      o__deq_data     <= '0;
      o__deq_priority <= '0;
      sec_valid       <= 1'b0;
      sec_data        <= '0;
      sec_prio        <= '0;
    end else if (accept) begin
      if (sec_valid) begin
        o__deq_data     <= sec_data;
        o__deq_priority <= sec_prio;
        if (o__pifo_pop) begin
          sec_data  <= i__pifo_pop_data;
          sec_prio  <= i__pifo_pop_priority;
        end else begin
          sec_valid <= 1'b0;
        end
      end else if (o__pifo_pop) begin
        o__deq_data     <= i__pifo_pop_data;
        o__deq_priority <= i__pifo_pop_priority;
      end else begin
        o__deq_valid <= 1'b0;
      end
    end else if (o__pifo_pop) begin
      if (!o__deq_valid) begin
        o__deq_valid    <= 1'b1;
        o__deq_data     <= i__pifo_pop_data;
        o__deq_priority <= i__pifo_pop_priority;
      end else begin
        sec_valid <= 1'b1;
        sec_data  <= i__pifo_pop_data;
        sec_prio  <= i__pifo_pop_priority;
      end
    end
  end

endmodule

// File: tb/tb_pifo_dequeue_ctrl.sv
// tb/tb_pifo_dequeue_ctrl.sv - randomized and directed bench for pifo_dequeue_ctrl against a queue-based model
module tb_pifo_dequeue_ctrl;

  localparam int Q = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       enable = 0, drain = 0, pvalid = 0, ready = 0;
  logic [7:0] pprio = 0, pdata = 0;
  logic       pop, dvalid, done;
  logic [7:0] reins, ddata, dprio;
  logic [15:0] pcount;

  logic       g_enable = 0, g_valid = 0, g_ready = 0;
  logic [7:0] g_prio = 8'd5, g_data = 8'h3C;
  logic       g_pop, g_dvalid, g_done;
  logic [7:0] g_reins, g_ddata, g_dprio;
  logic [15:0] g_count;

  always #5 clk = ~clk;

  pifo_dequeue_ctrl #(.PRIO_WIDTH(8), .DATA_WIDTH(8), .QUANTUM(Q), .GAP(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .i__enable(enable), .i__drain(drain),
    .i__pifo_pop_valid(pvalid), .i__pifo_pop_priority(pprio), .i__pifo_pop_data(pdata),
    .o__pifo_pop(pop), .o__pifo_reinsert_priority(reins), .o__deq_valid(dvalid),
    .o__deq_data(ddata), .o__deq_priority(dprio), .i__deq_ready(ready),
    .o__pop_count(pcount), .o__drain_done(done)
  );

  pifo_dequeue_ctrl #(.PRIO_WIDTH(8), .DATA_WIDTH(8), .QUANTUM(Q), .GAP(2), .CNT_WIDTH(16)) dut_gap (
    .clk(clk), .reset(reset), .i__enable(g_enable), .i__drain(1'b0),
    .i__pifo_pop_valid(g_valid), .i__pifo_pop_priority(g_prio), .i__pifo_pop_data(g_data),
    .o__pifo_pop(g_pop), .o__pifo_reinsert_priority(g_reins), .o__deq_valid(g_dvalid),
    .o__deq_data(g_ddata), .o__deq_priority(g_dprio), .i__deq_ready(g_ready),
    .o__pop_count(g_count), .o__drain_done(g_done)
  );

  int tests = 0;
  int fails = 0;

  // External PIFO contents (lowest priority value at the front) and model state.
  ent_t pifo[$];
  ent_t mbuf[$];
  int   mode = M_IDLE;
  int   mcount = 0;
  int   cyc = 0;
  int   last_pop = -1000;
  logic mask = 1'b1;

  logic [7:0] pop_log[$];
  ent_t       deq_log[$];
  logic       g_active = 1'b0;
  int         g_cyc_log[$];
  int         g_cnt_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pifo_insert(input ent_t e);
    int i;
    i = 0;
    while (i < pifo.size() && pifo[i].p <= e.p) i++;
    pifo.insert(i, e);
  endtask

  // One clock: drive PIFO head, compare at negedge, advance model at posedge.
  task automatic cycle();
    logic e_pop;
    logic [7:0] e_reins;
    int   bsize;
    ent_t head;
    pvalid = mask && (pifo.size() > 0);
    head   = (pifo.size() > 0) ? pifo[0] : '0;
    pprio  = head.p;
    pdata  = head.d;
    @(negedge clk);
    bsize   = mbuf.size();
    e_pop   = 1'b0;
    e_reins = 8'd0;
    if (!reset) begin
      chk("rst_pop", pop, 0);
      chk("rst_reins", reins, 0);
      chk("rst_dvalid", dvalid, 0);
      chk("rst_ddata", ddata, 0);
      chk("rst_dprio", dprio, 0);
      chk("rst_count", pcount, 0);
      chk("rst_done", done, 0);
    end else begin
      e_pop = (mode == M_RUN || mode == M_DRAIN) && pvalid && (cyc - last_pop > 0) && (bsize < 2);
      if (e_pop && mode == M_RUN && head.p > Q) e_reins = head.p - 8'(Q);
      chk("pop", pop, e_pop);
      chk("reinsert", reins, e_reins);
      chk("deq_valid", dvalid, bsize > 0);
      if (bsize > 0) begin
        chk("deq_data", ddata, mbuf[0].d);
        chk("deq_prio", dprio, mbuf[0].p);
      end
      chk("pop_count", pcount, mcount & 32'hFFFF);
      chk("drain_done", done, mode == M_DONE);
    end
    if (pop) pop_log.push_back(reins);
    if (g_active && g_pop) begin
      g_cyc_log.push_back(cyc);
      g_cnt_log.push_back(int'(g_count));
      chk("gap_reins", g_reins, 0);
    end
    @(posedge clk);
    if (!reset) begin
      mbuf.delete();
      mode = M_IDLE;
      mcount = 0;
      last_pop = -1000;
    end else begin
      if (bsize > 0 && ready) deq_log.push_back(mbuf.pop_front());
      if (e_pop) begin
        mbuf.push_back(head);
        void'(pifo.pop_front());
        if (e_reins != 0) pifo_insert('{p: e_reins, d: head.d});
        mcount++;
        last_pop = cyc;
      end
      case (mode)
        M_IDLE:  if (enable) mode = M_RUN;
        M_RUN:   if (drain) mode = M_DRAIN; else if (!enable) mode = M_IDLE;
        M_DRAIN: if (!pvalid && !e_pop && bsize == 0) mode = M_DONE;
        default: if (!enable && !drain) mode = M_IDLE;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    repeat (n) cycle();
    reset = 1'b1;
    pop_log.delete();
    deq_log.delete();
  endtask

  initial begin
    #1;
    // Reset with an eager PIFO and enable high: nothing may come out.
    enable = 1; mask = 1; ready = 1;
    pifo.push_back('{p: 8'd9, d: 8'h77});
    pvalid = 1; pprio = 8'd9;
    #1;
    chk("r035_pop", pop, 0);
    chk("r035_reins", reins, 0);
    chk("r035_dvalid", dvalid, 0);
    chk("r035_count", pcount, 0);
    chk("r035_done", done, 0);
    repeat (3) cycle();
    reset = 1'b1;

    // Reinsert chain: 40 -> 24 -> 8 -> gone.
    enable = 0;
    apply_reset(2);
    pifo.delete();
    pifo.push_back('{p: 8'd40, d: 8'hA5});
    enable = 1; ready = 1; mask = 1;
    repeat (8) cycle();
    chk("chain_npops", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      chk("chain_r0", pop_log[0], 24);
      chk("chain_r1", pop_log[1], 8);
      chk("chain_r2", pop_log[2], 0);
    end
    chk("chain_ndeq", deq_log.size(), 3);
    if (deq_log.size() == 3) begin
      chk("chain_p0", deq_log[0].p, 40);
      chk("chain_p1", deq_log[1].p, 24);
      chk("chain_p2", deq_log[2].p, 8);
      chk("chain_d2", deq_log[2].d, 8'hA5);
    end

    // Backpressure: only two pops fit the buffer.
    enable = 0;
    apply_reset(2);
    pifo.delete();
    pifo.push_back('{p: 8'd10, d: 8'h01});
    pifo.push_back('{p: 8'd12, d: 8'h02});
    pifo.push_back('{p: 8'd14, d: 8'h03});
    enable = 1; ready = 0;
    repeat (8) cycle();
    chk("bp_count", pcount, 2);
    chk("bp_pop", pop, 0);
    ready = 1;
    repeat (6) cycle();
    chk("bp_count_after", pcount, 3);
    chk("bp_ndeq", deq_log.size(), 3);
    if (deq_log.size() == 3) begin
      chk("bp_d0", deq_log[0].d, 1);
      chk("bp_d1", deq_log[1].d, 2);
      chk("bp_d2", deq_log[2].d, 3);
    end

    // GAP=2 instance: pops every third cycle.
    enable = 0;
    apply_reset(2);
    g_active = 1; g_enable = 1; g_valid = 1; g_ready = 1;
    repeat (14) cycle();
    g_active = 0; g_enable = 0; g_valid = 0;
    chk("gap_npops", g_cyc_log.size() >= 4, 1);
    for (int i = 1; i < g_cyc_log.size(); i++) begin
      chk("gap_spacing", g_cyc_log[i] - g_cyc_log[i-1], 3);
      chk("gap_count_step", g_cnt_log[i] - g_cnt_log[i-1], 1);
    end

    // Drain: enter RUN with no head, request drain, then two entries arrive.
    apply_reset(2);
    pifo.delete();
    pifo_insert('{p: 8'd50, d: 8'h11});
    pifo_insert('{p: 8'd30, d: 8'h22});
    mask = 0; enable = 1; ready = 1;
    repeat (2) cycle();
    drain = 1;
    cycle();
    mask = 1;
    repeat (6) cycle();
    chk("drain_npops", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      chk("drain_r0", pop_log[0], 0);
      chk("drain_r1", pop_log[1], 0);
    end
    chk("drain_done_lit", done, 1);
    chk("drain_count", pcount, 2);
    drain = 0; enable = 0;
    repeat (2) cycle();

    // Reset mid-operation with a full buffer.
    apply_reset(1);
    pifo.delete();
    pifo.push_back('{p: 8'd3, d: 8'hB1});
    pifo.push_back('{p: 8'd4, d: 8'hB2});
    pifo.push_back('{p: 8'd5, d: 8'hB3});
    enable = 1; ready = 0;
    repeat (6) cycle();
    chk("mid_dvalid_pre", dvalid, 1);
    reset = 0;
    #1;
    chk("mid_dvalid", dvalid, 0);
    chk("mid_count", pcount, 0);
    chk("mid_pop", pop, 0);
    repeat (2) cycle();
    reset = 1;
    ready = 1;
    repeat (8) cycle();
    chk("mid_resume_count", pcount, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      mask  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) drain = ~drain;
      if (pifo.size() < 3) pifo_insert('{p: 8'($urandom_range(1, 100)), d: 8'($urandom)});
      if (n == 1500) apply_reset(2);
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
